// File: rtl/sram_controller.sv
// Splits one 32-bit load/store into two 16-bit async SRAM phases with programmable wait states.
// Optional misalignment flag enabled by defining SRAM_ALIGN_CHECK_EN.
module sram_controller #(
  parameter int unsigned ADDR_BASE   = 1024,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wrEn,
  input  logic               rdEn,
  input  logic [31:0]        address,
  input  logic [31:0]        writeData,
  output logic [31:0]        readData,
  output logic               ready,
  output logic               addrErr,
  output logic [SRAM_AW-1:0] sramAddr,
  output logic [15:0]        sramDqOut,
  input  logic [15:0]        sramDqIn,
  output logic               sramDqOe,
  output logic               sramWeN
);

  typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [31:0]        rdata_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [15:0]        dout_q;

  logic [31:0]        off;
  logic [SRAM_AW-2:0] word;
  logic               req, is_rd, in_phase, is_high, last;
  logic               unused_off;

  assign off        = address - ADDR_BASE;
  assign word       = off[SRAM_AW:2];
  assign unused_off = ^{off[31:SRAM_AW+1], off[1:0]};
  assign req        = wrEn | rdEn;
  // A simultaneous load and store is treated as a store only.
  assign is_rd      = rdEn & ~wrEn;
  assign in_phase   = (state_q == StLow) || (state_q == StHigh);
  assign is_high    = (state_q == StHigh);
  assign last       = (cnt_q == 4'd0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = ~req;
        if (req) begin
          state_d = StLow;
          cnt_d   = WaitInit;
        end
      end
      StLow: begin
        if (last) begin
          state_d = StHigh;
          cnt_d   = WaitInit;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHigh: begin
        if (last) state_d = StDone;
        else      cnt_d   = cnt_q - 4'd1;
      end
      StDone: begin
        state_d = StIdle;
        ready   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sramAddr  = in_phase ? {word, is_high} : addr_q;
    sramDqOut = dout_q;
    if (in_phase && wrEn) sramDqOut = is_high ? writeData[31:16] : writeData[15:0];
    sramDqOe  = in_phase & wrEn;
    // WE is released on the last cycle of each phase for address/data hold, and
    // immediately by reset so an interrupted pulse never completes a write.
    sramWeN   = ~(in_phase & wrEn & ~last) | rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      addr_q  <= '0;
      dout_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (in_phase) begin
        addr_q <= sramAddr;
        dout_q <= sramDqOut;
      end
      if (in_phase && is_rd && last) begin
        if (is_high) rdata_q[31:16] <= sramDqIn;
        else         rdata_q[15:0]  <= sramDqIn;
      end
    end
  end

  assign readData = rdata_q;

`ifdef SRAM_ALIGN_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == StIdle && req && address[1:0] != 2'b00) begin
      err_q <= 1'b1;
    end
  end

  assign addrErr = err_q;
`else
  assign addrErr = 1'b0;
`endif

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Data-memory back end for the MEM stage of the 5-stage ARM pipeline. Replaces the single-cycle data memory.
- Converts one 32-bit load/store request into two 16-bit accesses on an external asynchronous SRAM, each with programmable wait states.
- Drives `ready` low while an access is in flight. The top level uses `~ready` to freeze every pipeline register and the PC.

Parameters:
- ADDR_BASE, 1024: CPU byte address that maps to SRAM word 0.
- WAIT_CYCLES, 1: extra cycles each 16-bit phase is held; range 0..15.
- SRAM_AW, 18: SRAM halfword address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wrEn  in  1  store request from EX/MEM
- rdEn  in  1  load request from EX/MEM
- address  in  32  byte address (ALU result)
- writeData  in  32  store data (Rm value)
- readData  out  32  load data to MEM/WB
- ready  out  1  1 = no access pending or access completing this cycle
- addrErr  out  1  sticky misalignment flag; see Optional Feature
- sramAddr  out  SRAM_AW  halfword address
- sramDqOut  out  16  write data to SRAM
- sramDqIn  in  16  read data from SRAM
- sramDqOe  out  1  1 = controller drives the data bus
- sramWeN  out  1  SRAM write enable, active-low

Behaviour:
- **Reset** (clk edge with rst=1, also mid-access): state=IDLE, wait counter=0, readData=0, addrErr=0, sramWeN=1, sramDqOe=0, sramAddr=0, sramDqOut=0. Any in-flight access is abandoned. No partial write continues after reset.
- **Address mapping:**
  - off = address - ADDR_BASE, modulo 2^32.
  - word = off[SRAM_AW:2].
  - Low half at sramAddr={word,0}; high half at {word,1}.
  - Bits above SRAM_AW are ignored, so the address wraps.
- **Request:** req = wrEn | rdEn. If both are set, the access is a write; it performs no read and leaves readData unchanged.
- **FSM states:** IDLE, LOW, HIGH, DONE.
  - IDLE: if req, go to LOW and load counter=WAIT_CYCLES. Otherwise stay.
  - LOW: drives the low half. When counter=0, go to HIGH and reload the counter; otherwise decrement.
  - HIGH: drives the high half. When counter=0, go to DONE; otherwise decrement.
  - DONE: go to IDLE unconditionally.
- **ready (combinational):**
  - 1 in DONE.
  - 1 in IDLE when req=0.
  - 0 otherwise, including IDLE with req=1.
- **Latency:** ready is low for exactly 1 + 2*(WAIT_CYCLES+1) cycles from the first cycle req is seen. It is then high for 1 cycle (DONE), during which the pipeline advances.
  - WAIT_CYCLES=1: 5 low cycles.
  - WAIT_CYCLES=0: 3 low cycles.
- **Request stability:** wrEn, rdEn, address and writeData must be held stable while ready=0. The controller samples them combinationally every cycle and does not latch them.
- **Back-to-back requests:** a new request arriving in the cycle after DONE is seen in IDLE and starts a fresh access. There is no overlap between accesses.
- **Write signalling:**
  - sramDqOe=1 in LOW and HIGH for writes.
  - sramDqOut = writeData[15:0] in LOW and writeData[31:16] in HIGH.
  - sramWeN=0 in every LOW/HIGH cycle except the final cycle of each phase (counter=0). This gives address/data hold before the next phase.
  - With WAIT_CYCLES=0, sramWeN stays 1 and no write is performed. WAIT_CYCLES≥1 is required for stores.
- **Read signalling:**
  - sramDqOe=0 and sramWeN=1 throughout.
  - readData[15:0] <= sramDqIn on the last LOW cycle; readData[31:16] <= sramDqIn on the last HIGH cycle.
  - readData is valid from DONE onward and is held until the next read's updates.
- **Outside LOW/HIGH:** sramWeN=1, sramDqOe=0, sramAddr holds its last value.

Optional Feature:
- **Macro:** SRAM_ALIGN_CHECK_EN.
- **Defined:** when a request is accepted in IDLE with address[1:0]≠0, addrErr is set to 1 on that edge. addrErr stays 1 until rst. The access still proceeds using word = off[SRAM_AW:2] (the low address bits are truncated).
- **Undefined:** addrErr is tied to 0 and there is no checking logic.

Test Plan (WAIT_CYCLES=1, ADDR_BASE=1024):
- Reset: hold rst=1 for 2 cycles → readData=0, ready=1, sramWeN=1, sramDqOe=0, addrErr=0.
- Store: wrEn=1, address=1028, writeData=0xDEADBEEF.
  - → ready=0 for 5 cycles, then 1 for 1 cycle.
  - → SRAM halfword 2 holds 0xBEEF and halfword 3 holds 0xDEAD.
  - → sramWeN low for exactly 1 cycle per phase.
- Load: rdEn=1, address=1028, with the SRAM model returning the written data → readData=0xDEADBEEF in the DONE cycle, still held 3 cycles after rdEn drops.
- Collision and back-to-back: wrEn=rdEn=1, writeData=0x12345678, address=1024, followed immediately by a load from 1024.
  - → the first access is a write only; readData is unchanged in its DONE cycle.
  - → the following load returns 0x12345678 after the IDLE cycle, with ready low 5 cycles.
- Reset mid-access: assert rst during the HIGH phase of a store to 1032.
  - → next cycle: IDLE, ready=1, sramWeN=1.
  - → the high halfword at SRAM address 5 is unwritten.
- Alignment (macro defined): rdEn=1, address=1030 → addrErr=1 from the next cycle and sticky after the access. The data read is SRAM halfwords 2 and 3.
